// File: rtl/tipi_bus_capture_shift.sv
// Captures TI-99/4A bus writes into a holding register and serialises them MSB-first to the Pi.
// Optional odd-parity trailer bit is enabled with `define TIPI_CAPTURE_PARITY_EN.
module tipi_bus_capture_shift #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ti_data_in,
  input  logic              ti_we_n,
  input  logic              ti_sel,
  input  logic              pi_le,
  input  logic              pi_sclk,
  output logic              pi_sdo,
  output logic [DATA_W-1:0] data_q,
  output logic              new_data,
  output logic              overrun
);

`ifdef TIPI_CAPTURE_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif
  localparam int CNT_W = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] weSync, selSync, leSync, sclkSync;
  logic                   weDly, selDly, leDly, sclkDly;
  logic                   weLast, selLast, leLast, sclkLast;
  logic                   weRise, leRise, sclkRise, commit;
  logic [DATA_W-1:0]      sampleQ;
  logic [FRAME_W-1:0]     shifter, loadVal, shifted;
  logic [CNT_W-1:0]       count;
  state_t                 state;

  assign weLast   = weSync[SYNC_STAGES-1];
  assign selLast  = selSync[SYNC_STAGES-1];
  assign leLast   = leSync[SYNC_STAGES-1];
  assign sclkLast = sclkSync[SYNC_STAGES-1];

  assign weRise   = weLast & ~weDly;
  assign leRise   = leLast & ~leDly;
  assign sclkRise = sclkLast & ~sclkDly;
  assign commit   = weRise & selDly;

  // Parity travels as the frame's last bit, so it is fixed at load time.
`ifdef TIPI_CAPTURE_PARITY_EN
  assign loadVal = {data_q, ~^data_q};
`else
  assign loadVal = data_q;
`endif
  assign shifted = {shifter[FRAME_W-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weSync   <= '1;
      selSync  <= '0;
      leSync   <= '0;
      sclkSync <= '0;
      weDly    <= 1'b1;
      selDly   <= 1'b0;
      leDly    <= 1'b0;
      sclkDly  <= 1'b0;
    end else begin
      weSync   <= {weSync[SYNC_STAGES-2:0], ti_we_n};
      selSync  <= {selSync[SYNC_STAGES-2:0], ti_sel};
      leSync   <= {leSync[SYNC_STAGES-2:0], pi_le};
      sclkSync <= {sclkSync[SYNC_STAGES-2:0], pi_sclk};
      weDly    <= weLast;
      selDly   <= selLast;
      leDly    <= leLast;
      sclkDly  <= sclkLast;
    end
  end

  // Bus data is sampled raw; the strobe qualifies it, last sample before the rise wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sampleQ  <= '0;
      data_q   <= '0;
      new_data <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (!weLast && selLast)
        sampleQ <= ti_data_in;
      if (commit)
        data_q <= sampleQ;
      if (leRise) begin
        new_data <= commit;
        overrun  <= 1'b0;
      end else if (commit) begin
        new_data <= 1'b1;
        if (new_data)
          overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shifter <= '0;
      pi_sdo  <= 1'b0;
      count   <= '0;
      state   <= IDLE;
    end else if (leRise) begin
      shifter <= loadVal;
      pi_sdo  <= loadVal[FRAME_W-1];
      count   <= '0;
      state   <= SHIFT;
    end else if (sclkRise && !leLast && state != IDLE) begin
      shifter <= shifted;
      pi_sdo  <= shifted[FRAME_W-1];
      if (state == SHIFT) begin
        count <= count + 1'b1;
        if (count + 1'b1 == CNT_W'(FRAME_W))
          state <= DONE;
      end
    end
  end

endmodule

// File: tb/tb_tipi_bus_capture_shift.sv
// Randomised self-checking bench for tipi_bus_capture_shift against a transaction-level model.
// Honours `define TIPI_CAPTURE_PARITY_EN for the expected frame contents.
module tb_tipi_bus_capture_shift;
  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] ti_data_in = '0;
  logic          ti_we_n = 1'b1;
  logic          ti_sel = 1'b0;
  logic          pi_le = 1'b0;
  logic          pi_sclk = 1'b0;
  logic          pi_sdo;
  logic [DW-1:0] data_q;
  logic          new_data;
  logic          overrun;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] mData = '0;
  logic          mNew = 1'b0;
  logic          mOvr = 1'b0;

  tipi_bus_capture_shift #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .ti_data_in(ti_data_in), .ti_we_n(ti_we_n),
    .ti_sel(ti_sel), .pi_le(pi_le), .pi_sclk(pi_sclk), .pi_sdo(pi_sdo),
    .data_q(data_q), .new_data(new_data), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Serial bit i of a frame for byte b: i=0 is visible right after the load.
  function automatic logic expBit(input logic [DW-1:0] b, input int i);
    if (i < DW) return b[DW-1-i];
`ifdef TIPI_CAPTURE_PARITY_EN
    if (i == DW) return ~^b;
`endif
    return 1'b0;
  endfunction

  task automatic checkState(input string tag);
    check({tag, "_data"}, 32'(data_q), 32'(mData));
    check({tag, "_new"}, 32'(new_data), 32'(mNew));
    check({tag, "_ovr"}, 32'(overrun), 32'(mOvr));
  endtask

  task automatic tiWrite(input logic [DW-1:0] b, input logic sel, input int lowClks);
    ti_data_in = b;
    ti_sel = sel;
    ti_we_n = 1'b0;
    tick(lowClks);
    ti_we_n = 1'b1;
    tick(SS + 2);
    ti_sel = 1'b0;
    if (sel) begin
      if (mNew) mOvr = 1'b1;
      mData = b;
      mNew = 1'b1;
    end
  endtask

  task automatic piLoad();
    pi_le = 1'b1;
    tick(4);
    pi_le = 1'b0;
    tick(4);
    mNew = 1'b0;
    mOvr = 1'b0;
  endtask

  task automatic piShift(input logic [DW-1:0] b, input string tag);
    check($sformatf("%s_bit0", tag), 32'(pi_sdo), 32'(expBit(b, 0)));
    for (int i = 1; i <= DW + 1; i++) begin
      pi_sclk = 1'b1;
      tick(4);
      check($sformatf("%s_bit%0d", tag, i), 32'(pi_sdo), 32'(expBit(b, i)));
      pi_sclk = 1'b0;
      tick(4);
    end
  endtask

  initial begin
    logic [DW-1:0] frameByte;
    int act;

    ti_data_in = 8'h5A;
    rst_n = 1'b0;
    tick(3);
    checkState("reset");
    check("reset_sdo", 32'(pi_sdo), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Commit latency: no update SS clks after the rise, update on the next one.
    ti_data_in = 8'hA5;
    ti_sel = 1'b1;
    ti_we_n = 1'b0;
    tick(6);
    ti_we_n = 1'b1;
    tick(SS);
    check("lat_early", 32'(data_q), 32'h00);
    tick(1);
    check("lat_data", 32'(data_q), 32'hA5);
    check("lat_new", 32'(new_data), 32'h1);
    tick(2);
    ti_sel = 1'b0;
    mData = 8'hA5;
    mNew = 1'b1;

    piLoad();
    checkState("readA5");
    piShift(8'hA5, "frameA5");

    tiWrite(8'h11, 1'b1, 6);
    tiWrite(8'hFF, 1'b1, 6);
    checkState("ovr_set");
    piLoad();
    checkState("ovr_clr");

    tiWrite(8'h3C, 1'b0, 6);
    checkState("nosel");

    // Commit and load detected on the same clk: shifter gets the old byte.
    ti_data_in = 8'h22;
    ti_sel = 1'b1;
    ti_we_n = 1'b0;
    tick(6);
    ti_we_n = 1'b1;
    pi_le = 1'b1;
    tick(4);
    pi_le = 1'b0;
    ti_sel = 1'b0;
    tick(4);
    mData = 8'h22;
    mNew = 1'b1;
    mOvr = 1'b0;
    checkState("race");
    piShift(8'hFF, "raceFrame");

    piLoad();
    for (int i = 0; i < 2; i++) begin
      pi_sclk = 1'b1;
      tick(4);
      pi_sclk = 1'b0;
      tick(4);
    end
    rst_n = 1'b0;
    tick(2);
    mData = '0;
    mNew = 1'b0;
    mOvr = 1'b0;
    checkState("midrst");
    check("midrst_sdo", 32'(pi_sdo), 32'h0);
    rst_n = 1'b1;
    tick(2);
    piLoad();
    piShift(8'h00, "postRst");

    for (int t = 0; t < 20; t++) begin
      act = int'($urandom_range(0, 3));
      if (act == 0) begin
        frameByte = mData;
        piLoad();
        checkState($sformatf("rnd%0d_rd", t));
        piShift(frameByte, $sformatf("rnd%0d_f", t));
      end else begin
        tiWrite(DW'($urandom), act != 1, int'($urandom_range(SS + 1, 6)));
        checkState($sformatf("rnd%0d_wr", t));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
